uxn_screen_cmd_sequencer: RTL and testbench
===========================================

Name: uxn_screen_cmd_sequencer

Overview:
- Register front-end for the Varvara screen device (ports 0x26–0x2F).
- Holds the auto, x, y and addr registers.
- Turns CPU writes to the pixel and sprite ports into 24-bit draw-queue entries, emitted one word per cycle on the draw queue's `data`/`we` inputs.
- Sequences multi-sprite auto-length runs and applies the auto-increments to x, y and addr.
- Sits between the CPU device bus and uxn_draw_queue.

Parameters:
- COORD_W, 9: coordinate field width in a queue word; coordinates ≥ 2^COORD_W are not encodable.
- ADDR_W, 16: sprite address width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- dev_we  in  1  screen device port write strobe
- dev_addr  in  4  port offset: 6=auto, 8/9=x hi/lo, A/B=y hi/lo, C/D=addr hi/lo, E=pixel, F=sprite
- dev_wdata  in  8  write data
- x_out  out  16  current x register (CPU readback)
- y_out  out  16  current y register
- addr_out  out  16  current addr register
- auto_out  out  8  current auto register
- queue_we  out  1  draw-queue write strobe
- queue_data  out  24  draw-queue word
- busy  out  1  sequencer active; CPU must not write while high
- drop_err  out  1  sticky: a dev_we arrived while busy

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous, active-high.
- Reset values: all registers, queue_we, queue_data, busy and drop_err are 0; state is IDLE. Reset mid-run aborts the run at the next edge, and no further words are emitted.
- Writes to ports 6 and 8–D in IDLE update the addressed byte at the edge; big-endian, hi byte at the even offset. No queue output.
- Pixel word 0, bits high to low:
  - layer
  - color[1:0]
  - fill
  - flipy
  - flipx
  - x[8:0]
  - y[8:0]
- Sprite word 0, bits high to low:
  - layer
  - color[1:0]
  - 0
  - 1
  - 2bpp
  - x[8:0]
  - y[8:0]
- Sprite word 1, bits high to low:
  - 4'b0
  - flipy
  - flipx
  - color[3:2]
  - addr[15:0]
- Byte field decode:
  - pixel byte: bit7 fill, bit6 layer, bit5 flipy, bit4 flipx, [1:0] color
  - sprite byte: bit7 2bpp, bit6 layer, bit5 flipy, bit4 flipx, [3:0] color
  - auto byte: [7:4] length, bit2 autoA, bit1 autoY, bit0 autoX
- State machine: IDLE, PIXEL, SPR_W0, SPR_W1, UPDATE. busy = (state != IDLE).
- Pixel write at edge T:
  - PIXEL during cycle T+1: queue_we=1 with word 0. Fill encodes flip bits as range direction.
  - UPDATE at T+2. For a non-fill pixel: x += autoX, y += autoY. Fill: no increment.
  - IDLE at T+3.
- Sprite write: run n = length+1 sprites, index i = 0..n-1.
  - x_i = X + 8*i*autoY*(flipx ? -1 : 1).
  - y_i = Y + 8*i*autoX*(flipy ? -1 : 1).
  - a_i = A + i*autoA*(2bpp ? 16 : 8).
  - All arithmetic is 16-bit modulo.
  - Each sprite takes SPR_W0 (word 0), then SPR_W1 (word 1), with queue_we=1 on both. That is 2n consecutive queue_we cycles starting at T+1.
- Off-range sprite: if x_i or y_i ≥ 2^COORD_W (unsigned, which includes negatives), both words are skipped. queue_we stays 0 for those two cycles and i still advances. Timing is identical to the emitted case.
- UPDATE after a sprite run:
  - if autoX, X += 8*(flipx ? -1 : 1)
  - if autoY, Y += 8*(flipy ? -1 : 1)
  - if autoA, A = a_{n}
- dev_we while busy is ignored, and drop_err is set. drop_err clears only on reset.
- Pixel coordinates ≥ 2^COORD_W: no word is emitted; the PIXEL cycle has queue_we=0 and increments still apply.
- No queue-full backpressure: the downstream 4096-entry queue is sized for the maximum run of 32 words.

Decomposition:
- Shared package holds:
  - port offsets
  - bit positions of the pixel, sprite and auto bytes
  - queue word field positions (LAYER_BIT=23, COLOR_LO=22:21, FILL_BIT=20, SPRITE_BIT=19, MODE_BIT=18)
  - state enum
- One sub-module: uxn_screen_word_pack, which is a combinational packing of fields into word 0 and word 1 and is reusable by the verification model.

Test Plan:
- x=0x0010, y=0x0020, auto=0x01, pixel 0x41 -> a single queue_we with 0xA02020; afterwards x_out=0x0011 and y_out=0x0020.
- x=100, y=50, pixel 0x93 (fill, flipx, color 3) -> a single word 0x74C832; x and y unchanged.
- x=8, y=8, addr=0x1000, auto=0x15, sprite 0x81 -> 4 consecutive words 0x2C1008, 0x001000, 0x2C1010, 0x001010; afterwards x=0x0010, y=0x0008, addr=0x1020.
- x=0xFFFC, y=0, auto=0x00, sprite 0x01 -> busy for 3 cycles, zero queue_we, registers unchanged.
- Write to port 8 during a sprite run -> ignored, x unchanged, drop_err=1 until reset.
- reset asserted on the second queue_we cycle of a 16-sprite run -> the next cycle has queue_we=0, busy=0 and all registers 0.

Source files
------------

// File: rtl/uxn_screen_cmd_sequencer_pkg.sv
// Shared definitions for the Varvara screen command sequencer.
// Holds the device port offsets, the bit positions of the pixel, sprite and
// auto bytes, the queue-word field positions and the sequencer state enum.
package uxn_screen_cmd_sequencer_pkg;

  // Device port offsets (low nibble of the screen device address)
  localparam logic [3:0] PORT_AUTO   = 4'h6;
  localparam logic [3:0] PORT_X_HI   = 4'h8;
  localparam logic [3:0] PORT_X_LO   = 4'h9;
  localparam logic [3:0] PORT_Y_HI   = 4'hA;
  localparam logic [3:0] PORT_Y_LO   = 4'hB;
  localparam logic [3:0] PORT_A_HI   = 4'hC;
  localparam logic [3:0] PORT_A_LO   = 4'hD;
  localparam logic [3:0] PORT_PIXEL  = 4'hE;
  localparam logic [3:0] PORT_SPRITE = 4'hF;

  // Pixel / sprite command byte fields
  localparam int PIX_FILL_BIT  = 7;
  localparam int SPR_2BPP_BIT  = 7;
  localparam int CMD_LAYER_BIT = 6;
  localparam int CMD_FLIPY_BIT = 5;
  localparam int CMD_FLIPX_BIT = 4;

  // Auto byte fields
  localparam int AUTO_LEN_HI = 7;
  localparam int AUTO_LEN_LO = 4;
  localparam int AUTO_A_BIT  = 2;
  localparam int AUTO_Y_BIT  = 1;
  localparam int AUTO_X_BIT  = 0;

  // Queue word field positions
  localparam int QWORD_W    = 24;
  localparam int LAYER_BIT  = 23;
  localparam int COLOR_HI   = 22;
  localparam int COLOR_LO   = 21;
  localparam int FILL_BIT   = 20;
  localparam int SPRITE_BIT = 19;
  localparam int MODE_BIT   = 18;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PIXEL  = 3'd1,
    ST_SPR_W0 = 3'd2,
    ST_SPR_W1 = 3'd3,
    ST_UPDATE = 3'd4
  } state_t;

endpackage

// File: rtl/uxn_screen_word_pack.sv
// Combinational packing of a pixel/sprite command byte plus coordinates and
// address into draw-queue words.
// Ports:
//   cmd      - pixel or sprite command byte
//   x, y     - 16-bit coordinates of the primitive
//   addr     - sprite address
//   pix_w0   - pixel word 0
//   spr_w0   - sprite word 0
//   spr_w1   - sprite word 1 (flips, color[3:2], address)
//   coord_ok - both coordinates fit in COORD_W bits
module uxn_screen_word_pack
  import uxn_screen_cmd_sequencer_pkg::*;
#(
  parameter int COORD_W = 9,
  parameter int ADDR_W  = 16
) (
  input  logic [7:0]         cmd,
  input  logic [15:0]        x,
  input  logic [15:0]        y,
  input  logic [ADDR_W-1:0]  addr,
  output logic [QWORD_W-1:0] pix_w0,
  output logic [QWORD_W-1:0] spr_w0,
  output logic [QWORD_W-1:0] spr_w1,
  output logic               coord_ok
);

  // Field placement for all three word formats
  always_comb begin
    pix_w0 = '0;
    pix_w0[LAYER_BIT]              = cmd[CMD_LAYER_BIT];
    pix_w0[COLOR_HI:COLOR_LO]      = cmd[1:0];
    pix_w0[FILL_BIT]               = cmd[PIX_FILL_BIT];
    // For pixels the flip bits give the fill direction
    pix_w0[SPRITE_BIT]             = cmd[CMD_FLIPY_BIT];
    pix_w0[MODE_BIT]               = cmd[CMD_FLIPX_BIT];
    pix_w0[2*COORD_W-1:COORD_W]    = x[COORD_W-1:0];
    pix_w0[COORD_W-1:0]            = y[COORD_W-1:0];

    spr_w0 = '0;
    spr_w0[LAYER_BIT]              = cmd[CMD_LAYER_BIT];
    spr_w0[COLOR_HI:COLOR_LO]      = cmd[1:0];
    spr_w0[FILL_BIT]               = 1'b0;
    spr_w0[SPRITE_BIT]             = 1'b1;
    spr_w0[MODE_BIT]               = cmd[SPR_2BPP_BIT];
    spr_w0[2*COORD_W-1:COORD_W]    = x[COORD_W-1:0];
    spr_w0[COORD_W-1:0]            = y[COORD_W-1:0];

    // Word 1 reuses bits 19/18 for the flips, color[3:2] sits just above addr
    spr_w1 = '0;
    spr_w1[SPRITE_BIT]             = cmd[CMD_FLIPY_BIT];
    spr_w1[MODE_BIT]               = cmd[CMD_FLIPX_BIT];
    spr_w1[ADDR_W+1:ADDR_W]        = cmd[3:2];
    spr_w1[ADDR_W-1:0]             = addr;

    // Unsigned range test: negative coordinates wrap high and are rejected
    coord_ok = (x[15:COORD_W] == '0) && (y[15:COORD_W] == '0);
  end

endmodule

// File: rtl/uxn_screen_cmd_sequencer.sv
// Register front-end for the Varvara screen device (ports 0x26-0x2F).
// Holds auto/x/y/addr, turns pixel and sprite port writes into draw-queue
// words (one per cycle) and applies the auto-increments afterwards.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   dev_we/addr/wdata     - CPU device-port write
//   x_out/y_out/addr_out/auto_out - register readback
//   queue_we/queue_data   - draw-queue write strobe and word
//   busy                  - sequencer active, CPU writes are dropped
//   drop_err              - sticky flag: a write arrived while busy
module uxn_screen_cmd_sequencer
  import uxn_screen_cmd_sequencer_pkg::*;
#(
  parameter int COORD_W = 9,
  parameter int ADDR_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dev_we,
  input  logic [3:0]         dev_addr,
  input  logic [7:0]         dev_wdata,
  output logic [15:0]        x_out,
  output logic [15:0]        y_out,
  output logic [ADDR_W-1:0]  addr_out,
  output logic [7:0]         auto_out,
  output logic               queue_we,
  output logic [QWORD_W-1:0] queue_data,
  output logic               busy,
  output logic               drop_err
);

  state_t              state_r;
  logic [15:0]         x_r, y_r, cur_x_r, cur_y_r;
  logic [ADDR_W-1:0]   addr_r, cur_a_r;
  logic [7:0]          auto_r, cmd_r;
  logic                is_spr_r;
  logic [3:0]          idx_r;

  logic [15:0]         step_x_s, step_y_s, next_x_s, next_y_s;
  logic [ADDR_W-1:0]   step_a_s, next_a_s;
  logic [7:0]          pk_cmd_s;
  logic [15:0]         pk_x_s, pk_y_s;
  logic [ADDR_W-1:0]   pk_a_s;
  logic [QWORD_W-1:0]  pix_w0_s, spr_w0_s, spr_w1_s;
  logic                coord_ok_s;

  assign x_out    = x_r;
  assign y_out    = y_r;
  assign addr_out = addr_r;
  assign auto_out = auto_r;
  assign busy     = (state_r != ST_IDLE);

  // Per-sprite steps: x advances with autoY, y with autoX (Varvara quirk)
  always_comb begin
    if (auto_r[AUTO_Y_BIT]) begin
      step_x_s = cmd_r[CMD_FLIPX_BIT] ? 16'hFFF8 : 16'h0008;
    end else begin
      step_x_s = 16'h0000;
    end
    if (auto_r[AUTO_X_BIT]) begin
      step_y_s = cmd_r[CMD_FLIPY_BIT] ? 16'hFFF8 : 16'h0008;
    end else begin
      step_y_s = 16'h0000;
    end
    if (auto_r[AUTO_A_BIT]) begin
      step_a_s = cmd_r[SPR_2BPP_BIT] ? ADDR_W'(5'd16) : ADDR_W'(5'd8);
    end else begin
      step_a_s = '0;
    end
    next_x_s = cur_x_r + step_x_s;
    next_y_s = cur_y_r + step_y_s;
    next_a_s = cur_a_r + step_a_s;
  end

  // Packer source: the incoming byte in IDLE, the next sprite when wrapping
  // from word 1 to the following word 0, otherwise the current sprite
  always_comb begin
    if (state_r == ST_IDLE) begin
      pk_cmd_s = dev_wdata;
      pk_x_s   = x_r;
      pk_y_s   = y_r;
      pk_a_s   = addr_r;
    end else if (state_r == ST_SPR_W1) begin
      pk_cmd_s = cmd_r;
      pk_x_s   = next_x_s;
      pk_y_s   = next_y_s;
      pk_a_s   = next_a_s;
    end else begin
      pk_cmd_s = cmd_r;
      pk_x_s   = cur_x_r;
      pk_y_s   = cur_y_r;
      pk_a_s   = cur_a_r;
    end
  end

  uxn_screen_word_pack #(
    .COORD_W (COORD_W),
    .ADDR_W  (ADDR_W)
  ) u_pack (
    .cmd      (pk_cmd_s),
    .x        (pk_x_s),
    .y        (pk_y_s),
    .addr     (pk_a_s),
    .pix_w0   (pix_w0_s),
    .spr_w0   (spr_w0_s),
    .spr_w1   (spr_w1_s),
    .coord_ok (coord_ok_s)
  );

  // Register file, sequencer FSM and registered queue outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      x_r        <= '0;
      y_r        <= '0;
      addr_r     <= '0;
      auto_r     <= '0;
      cmd_r      <= '0;
      is_spr_r   <= 1'b0;
      idx_r      <= '0;
      cur_x_r    <= '0;
      cur_y_r    <= '0;
      cur_a_r    <= '0;
      queue_we   <= 1'b0;
      queue_data <= '0;
      drop_err   <= 1'b0;
    end else begin
      queue_we <= 1'b0;
      if (dev_we && (state_r != ST_IDLE)) begin
        drop_err <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (dev_we) begin
            case (dev_addr)
              PORT_AUTO: auto_r              <= dev_wdata;
              PORT_X_HI: x_r[15:8]           <= dev_wdata;
              PORT_X_LO: x_r[7:0]            <= dev_wdata;
              PORT_Y_HI: y_r[15:8]           <= dev_wdata;
              PORT_Y_LO: y_r[7:0]            <= dev_wdata;
              PORT_A_HI: addr_r[ADDR_W-1:8]  <= dev_wdata[ADDR_W-9:0];
              PORT_A_LO: addr_r[7:0]         <= dev_wdata;
              PORT_PIXEL: begin
                cmd_r      <= dev_wdata;
                is_spr_r   <= 1'b0;
                queue_we   <= coord_ok_s;
                queue_data <= pix_w0_s;
                state_r    <= ST_PIXEL;
              end
              PORT_SPRITE: begin
                cmd_r      <= dev_wdata;
                is_spr_r   <= 1'b1;
                idx_r      <= 4'd0;
                cur_x_r    <= x_r;
                cur_y_r    <= y_r;
                cur_a_r    <= addr_r;
                queue_we   <= coord_ok_s;
                queue_data <= spr_w0_s;
                state_r    <= ST_SPR_W0;
              end
              default: state_r <= ST_IDLE;
            endcase
          end
        end
        ST_PIXEL: state_r <= ST_UPDATE;
        ST_SPR_W0: begin
          // Off-range sprites stay silent for both words but keep the timing
          queue_we   <= coord_ok_s;
          queue_data <= spr_w1_s;
          state_r    <= ST_SPR_W1;
        end
        ST_SPR_W1: begin
          // cur_* always advances, so after the last sprite cur_a_r holds a_n
          cur_x_r <= next_x_s;
          cur_y_r <= next_y_s;
          cur_a_r <= next_a_s;
          if (idx_r == auto_r[AUTO_LEN_HI:AUTO_LEN_LO]) begin
            state_r <= ST_UPDATE;
          end else begin
            idx_r      <= idx_r + 4'd1;
            queue_we   <= coord_ok_s;
            queue_data <= spr_w0_s;
            state_r    <= ST_SPR_W0;
          end
        end
        ST_UPDATE: begin
          if (is_spr_r) begin
            if (auto_r[AUTO_X_BIT]) begin
              x_r <= x_r + (cmd_r[CMD_FLIPX_BIT] ? 16'hFFF8 : 16'h0008);
            end
            if (auto_r[AUTO_Y_BIT]) begin
              y_r <= y_r + (cmd_r[CMD_FLIPY_BIT] ? 16'hFFF8 : 16'h0008);
            end
            if (auto_r[AUTO_A_BIT]) begin
              addr_r <= cur_a_r;
            end
          end else if (!cmd_r[PIX_FILL_BIT]) begin
            x_r <= x_r + {15'd0, auto_r[AUTO_X_BIT]};
            y_r <= y_r + {15'd0, auto_r[AUTO_Y_BIT]};
          end
          state_r <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uxn_screen_cmd_sequencer.sv
// Self-checking bench for uxn_screen_cmd_sequencer: a table of directed
// command vectors plus hand-written drop-while-busy and mid-run reset cases.
module tb_uxn_screen_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        dev_we;
  logic [3:0]  dev_addr;
  logic [7:0]  dev_wdata;
  logic [15:0] x_out, y_out, addr_out;
  logic [7:0]  auto_out;
  logic        queue_we;
  logic [23:0] queue_data;
  logic        busy;
  logic        drop_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uxn_screen_cmd_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .dev_we     (dev_we),
    .dev_addr   (dev_addr),
    .dev_wdata  (dev_wdata),
    .x_out      (x_out),
    .y_out      (y_out),
    .addr_out   (addr_out),
    .auto_out   (auto_out),
    .queue_we   (queue_we),
    .queue_data (queue_data),
    .busy       (busy),
    .drop_err   (drop_err)
  );

  typedef struct packed {
    logic [15:0]       x;
    logic [15:0]       y;
    logic [15:0]       a;
    logic [7:0]        auto_v;
    logic [3:0]        port;
    logic [7:0]        data;
    logic [3:0]        nw;
    logic [3:0][23:0]  w;
    logic [3:0][7:0]   off;
    logic [7:0]        nb;
    logic [15:0]       ex;
    logic [15:0]       ey;
    logic [15:0]       ea;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] p, input logic [7:0] d);
    @(negedge clk);
    dev_we    = 1'b1;
    dev_addr  = p;
    dev_wdata = d;
    @(negedge clk);
    dev_we    = 1'b0;
  endtask

  task automatic setup(input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] a, input logic [7:0] au);
    wr(4'h6, au);
    wr(4'h8, x[15:8]);
    wr(4'h9, x[7:0]);
    wr(4'hA, y[15:8]);
    wr(4'hB, y[7:0]);
    wr(4'hC, a[15:8]);
    wr(4'hD, a[7:0]);
  endtask

  // Issues a command and records words, their cycle offsets and busy length
  task automatic run_cmd(input logic [3:0] p, input logic [7:0] d, output int nw,
                         output logic [3:0][23:0] w, output logic [3:0][7:0] off,
                         output int nb);
    nw = 0;
    nb = 0;
    w = '0;
    off = '0;
    wr(p, d);
    for (int c = 1; c <= 64; c++) begin
      if (!busy) break;
      nb++;
      if (queue_we) begin
        if (nw < 4) begin
          w[nw]   = queue_data;
          off[nw] = 8'(c);
        end
        nw++;
      end
      @(negedge clk);
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int nw, nb;
    logic [3:0][23:0] w;
    logic [3:0][7:0] off;

    //          x       y       a       auto   port  data  nw   words {w3,w2,w1,w0}                              offs {o3..o0}            nb    ex      ey      ea
    vecs[0] = '{16'h0010, 16'h0020, 16'h0000, 8'h01, 4'hE, 8'h41, 4'd1, {24'h0, 24'h0, 24'h0, 24'hA02020}, {8'd0, 8'd0, 8'd0, 8'd1}, 8'd2, 16'h0011, 16'h0020, 16'h0000};
    vecs[1] = '{16'd100,  16'd50,   16'h0000, 8'h03, 4'hE, 8'h93, 4'd1, {24'h0, 24'h0, 24'h0, 24'h74C832}, {8'd0, 8'd0, 8'd0, 8'd1}, 8'd2, 16'd100,  16'd50,   16'h0000};
    vecs[2] = '{16'h0008, 16'h0008, 16'h1000, 8'h15, 4'hF, 8'h81, 4'd4, {24'h001010, 24'h2C1010, 24'h001000, 24'h2C1008}, {8'd4, 8'd3, 8'd2, 8'd1}, 8'd5, 16'h0010, 16'h0008, 16'h1020};
    vecs[3] = '{16'hFFFC, 16'h0000, 16'h0000, 8'h00, 4'hF, 8'h01, 4'd0, {24'h0, 24'h0, 24'h0, 24'h0}, {8'd0, 8'd0, 8'd0, 8'd0}, 8'd3, 16'hFFFC, 16'h0000, 16'h0000};
    vecs[4] = '{16'h0200, 16'h0000, 16'h0000, 8'h03, 4'hE, 8'h01, 4'd0, {24'h0, 24'h0, 24'h0, 24'h0}, {8'd0, 8'd0, 8'd0, 8'd0}, 8'd2, 16'h0201, 16'h0001, 16'h0000};
    vecs[5] = '{16'h0020, 16'h0010, 16'h0200, 8'h16, 4'hF, 8'h15, 4'd4, {24'h050208, 24'h283010, 24'h050200, 24'h284010}, {8'd4, 8'd3, 8'd2, 8'd1}, 8'd5, 16'h0020, 16'h0018, 16'h0210};
    vecs[6] = '{16'h0000, 16'h0000, 16'h0000, 8'h12, 4'hF, 8'h10, 4'd2, {24'h0, 24'h0, 24'h040000, 24'h080000}, {8'd0, 8'd0, 8'd2, 8'd1}, 8'd5, 16'h0000, 16'h0008, 16'h0000};

    reset = 1'b1;
    dev_we = 1'b0;
    dev_addr = 4'h0;
    dev_wdata = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_x", {16'd0, x_out}, 32'd0);
    chk("rst_auto", {24'd0, auto_out}, 32'd0);
    chk("rst_qwe", {31'd0, queue_we}, 32'd0);
    chk("rst_qdata", {8'd0, queue_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_drop", {31'd0, drop_err}, 32'd0);

    for (int i = 0; i < 7; i++) begin
      setup(vecs[i].x, vecs[i].y, vecs[i].a, vecs[i].auto_v);
      chk($sformatf("v%0d_auto_rb", i), {24'd0, auto_out}, {24'd0, vecs[i].auto_v});
      run_cmd(vecs[i].port, vecs[i].data, nw, w, off, nb);
      chk($sformatf("v%0d_nwords", i), nw, {28'd0, vecs[i].nw});
      chk($sformatf("v%0d_busy_cycles", i), nb, {24'd0, vecs[i].nb});
      for (int k = 0; k < 4; k++) begin
        if (k < int'(vecs[i].nw)) begin
          chk($sformatf("v%0d_word%0d", i, k), {8'd0, w[k]}, {8'd0, vecs[i].w[k]});
          chk($sformatf("v%0d_off%0d", i, k), {24'd0, off[k]}, {24'd0, vecs[i].off[k]});
        end
      end
      chk($sformatf("v%0d_x", i), {16'd0, x_out}, {16'd0, vecs[i].ex});
      chk($sformatf("v%0d_y", i), {16'd0, y_out}, {16'd0, vecs[i].ey});
      chk($sformatf("v%0d_addr", i), {16'd0, addr_out}, {16'd0, vecs[i].ea});
    end
    chk("drop_before", {31'd0, drop_err}, 32'd0);

    // Write to port 8 during a 4-sprite run is dropped and flagged
    setup(16'h0040, 16'h0008, 16'h0000, 8'h30);
    wr(4'hF, 8'h01);
    @(negedge clk);
    dev_we = 1'b1;
    dev_addr = 4'h8;
    dev_wdata = 8'h55;
    @(negedge clk);
    dev_we = 1'b0;
    for (int c = 0; c < 64; c++) begin
      if (!busy) break;
      @(negedge clk);
    end
    chk("drop_idle", {31'd0, busy}, 32'd0);
    chk("drop_x", {16'd0, x_out}, 32'h0040);
    chk("drop_flag", {31'd0, drop_err}, 32'd1);
    wr(4'h6, 8'h00);
    chk("drop_idle_write", {24'd0, auto_out}, 32'd0);
    chk("drop_sticky", {31'd0, drop_err}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("drop_cleared", {31'd0, drop_err}, 32'd0);

    // Reset on the second queue_we cycle of a 16-sprite run
    setup(16'h0008, 16'h0008, 16'h0100, 8'hF1);
    wr(4'hF, 8'h01);
    chk("mr_we1", {31'd0, queue_we}, 32'd1);
    @(negedge clk);
    chk("mr_we2", {31'd0, queue_we}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mr_qwe", {31'd0, queue_we}, 32'd0);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_x", {16'd0, x_out}, 32'd0);
    chk("mr_y", {16'd0, y_out}, 32'd0);
    chk("mr_addr", {16'd0, addr_out}, 32'd0);
    chk("mr_auto", {24'd0, auto_out}, 32'd0);
    @(negedge clk);
    chk("mr_qwe_after", {31'd0, queue_we}, 32'd0);
    chk("mr_busy_after", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
